// File: rtl/riscv_pkg.sv
// Shared RV32 constants for the fetch stage: data width, canonical NOP and reset vector.
package riscv_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] NOP_INSTR    = 32'h0000_0013;
    localparam logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000;

    // Instruction memory is word addressed; byte PCs drop their two low bits.
    function automatic logic [XLEN-1:0] word_index(input logic [XLEN-1:0] byte_addr);
        return byte_addr >> 2;
    endfunction

    function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] byte_addr);
        return byte_addr & ~32'h0000_0003;
    endfunction

endpackage

// File: rtl/instr_fetch_pc_reg.sv
// Program counter flop: reset to a vector, load an aligned redirect target,
// hold, or advance by one instruction (wraps silently at 2^32).
module instr_fetch_pc_reg
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_VECTOR
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic [XLEN-1:0] load_addr,
    input  logic            hold,
    output logic [XLEN-1:0] pc
);

    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] pc_d;

    // Priority: load beats hold, so a redirect always lands even while decode is stalled.
    always_comb begin
        pc_d = pc_q;
        if (load) begin
            pc_d = align_word(load_addr);
        end else if (!hold) begin
            pc_d = pc_q + 32'd4;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q <= align_word(RESET_PC);
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc = pc_q;

endmodule

// File: rtl/instr_fetch.sv
// RV32 fetch stage: PC, instruction memory address, IF/ID register, fault flag.
// Define IFETCH_PERF_EN to build the fetch/stall performance counters.
module instr_fetch
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = RESET_VECTOR,
    parameter int          MEM_WORDS = 30
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            Stall,
    input  logic            Redirect,
    input  logic [XLEN-1:0] Redirect_PC,
    output logic [XLEN-1:0] Mem_Addr,
    input  logic [XLEN-1:0] Mem_Instr,
    output logic [XLEN-1:0] IF_PC,
    output logic [XLEN-1:0] IF_Instr,
    output logic            IF_Valid,
    output logic            Fetch_Fault,
    output logic [XLEN-1:0] Fetch_Count,
    output logic [XLEN-1:0] Stall_Count
);

    localparam logic [XLEN-1:0] MEM_LIMIT = 32'(MEM_WORDS);

    logic [XLEN-1:0] pc_q;
    logic            in_range;
    logic            advance;
    logic            latch_valid;

    // IF/ID handshake: IF_Valid marks a real instruction; Stall from decode freezes
    // the register and PC; Redirect flushes IF/ID to a bubble regardless of Stall.
    assign advance     = !Redirect && !Stall;
    assign in_range    = Mem_Addr < MEM_LIMIT;
    assign latch_valid = advance && in_range;

    instr_fetch_pc_reg #(
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk       (clk),
        .rst       (rst),
        .load      (Redirect),
        .load_addr (Redirect_PC),
        .hold      (Stall),
        .pc        (pc_q)
    );

    assign Mem_Addr = word_index(pc_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            IF_PC    <= '0;
            IF_Instr <= NOP_INSTR;
            IF_Valid <= 1'b0;
        end else if (Redirect) begin
            IF_PC    <= '0;
            IF_Instr <= NOP_INSTR;
            IF_Valid <= 1'b0;
        end else if (!Stall) begin
            IF_PC <= pc_q;
            // Out-of-range words are never sampled, so X from memory cannot leak into decode.
            if (in_range) begin
                IF_Instr <= Mem_Instr;
                IF_Valid <= 1'b1;
            end else begin
                IF_Instr <= NOP_INSTR;
                IF_Valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            Fetch_Fault <= 1'b0;
        end else if (advance && !in_range) begin
            Fetch_Fault <= 1'b1;
        end
    end

`ifdef IFETCH_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            Fetch_Count <= '0;
            Stall_Count <= '0;
        end else begin
            if (latch_valid) begin
                Fetch_Count <= Fetch_Count + 32'd1;
            end
            if (Stall) begin
                Stall_Count <= Stall_Count + 32'd1;
            end
        end
    end
`else
    assign Fetch_Count = '0;
    assign Stall_Count = '0;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: reset, advance, stall, redirect, alignment, fault, perf counters.
module tb_instr_fetch;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] mem_addr;
    logic [31:0] mem_instr;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic        if_valid;
    logic        fetch_fault;
    logic [31:0] fetch_count;
    logic [31:0] stall_count;

    logic [31:0] mem [0:31];
    int          checks;
    int          fails;

    localparam logic [31:0] NOP = 32'h0000_0013;

    instr_fetch #(
        .RESET_PC  (32'h0000_0000),
        .MEM_WORDS (30)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .Stall       (stall),
        .Redirect    (redirect),
        .Redirect_PC (redirect_pc),
        .Mem_Addr    (mem_addr),
        .Mem_Instr   (mem_instr),
        .IF_PC       (if_pc),
        .IF_Instr    (if_instr),
        .IF_Valid    (if_valid),
        .Fetch_Fault (fetch_fault),
        .Fetch_Count (fetch_count),
        .Stall_Count (stall_count)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Combinational instruction memory; words past depth return X.
    assign mem_instr = (mem_addr < 32'd30) ? mem[mem_addr[4:0]] : 32'hxxxx_xxxx;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int cycles);
        rst = 1'b1;
        for (int i = 0; i < cycles; i++) tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
        do_reset(3);
        checks++; if (if_pc !== 32'h0) begin fails++; $display("FAIL reset_if_pc got=%h exp=%h", if_pc, 32'h0); end
        checks++; if (if_instr !== NOP) begin fails++; $display("FAIL reset_if_instr got=%h exp=%h", if_instr, NOP); end
        checks++; if (if_valid !== 1'b0) begin fails++; $display("FAIL reset_if_valid got=%b exp=0", if_valid); end
        checks++; if (fetch_fault !== 1'b0) begin fails++; $display("FAIL reset_fault got=%b exp=0", fetch_fault); end
        checks++; if (mem_addr !== 32'h0) begin fails++; $display("FAIL reset_mem_addr got=%h exp=0", mem_addr); end
    endtask

    task automatic test_advance();
        for (int k = 0; k < 4; k++) begin
            tick();
            checks++; if (if_instr !== mem[k]) begin fails++; $display("FAIL adv_instr[%0d] got=%h exp=%h", k, if_instr, mem[k]); end
            checks++; if (if_pc !== 32'(k * 4)) begin fails++; $display("FAIL adv_pc[%0d] got=%h exp=%h", k, if_pc, 32'(k * 4)); end
            checks++; if (if_valid !== 1'b1) begin fails++; $display("FAIL adv_valid[%0d] got=%b exp=1", k, if_valid); end
        end
        checks++; if (mem_addr !== 32'd4) begin fails++; $display("FAIL adv_mem_addr got=%h exp=4", mem_addr); end
    endtask

    task automatic test_stall();
        do_reset(1);
        tick();
        tick();
        checks++; if (if_instr !== mem[1]) begin fails++; $display("FAIL stall_pre got=%h exp=%h", if_instr, mem[1]); end
        stall = 1'b1;
        for (int k = 0; k < 2; k++) begin
            tick();
            checks++; if (if_instr !== mem[1]) begin fails++; $display("FAIL stall_hold_instr[%0d] got=%h exp=%h", k, if_instr, mem[1]); end
            checks++; if (if_pc !== 32'h4) begin fails++; $display("FAIL stall_hold_pc[%0d] got=%h exp=4", k, if_pc); end
            checks++; if (mem_addr !== 32'd2) begin fails++; $display("FAIL stall_mem_addr[%0d] got=%h exp=2", k, mem_addr); end
        end
        stall = 1'b0;
        tick();
        checks++; if (if_instr !== mem[2]) begin fails++; $display("FAIL stall_release got=%h exp=%h", if_instr, mem[2]); end
        checks++; if (if_pc !== 32'h8) begin fails++; $display("FAIL stall_release_pc got=%h exp=8", if_pc); end
    endtask

    task automatic test_redirect();
        redirect = 1'b1; redirect_pc = 32'h10; stall = 1'b1;
        tick();
        redirect = 1'b0; stall = 1'b0;
        checks++; if (if_valid !== 1'b0) begin fails++; $display("FAIL redir_valid got=%b exp=0", if_valid); end
        checks++; if (if_instr !== NOP) begin fails++; $display("FAIL redir_instr got=%h exp=%h", if_instr, NOP); end
        checks++; if (mem_addr !== 32'd4) begin fails++; $display("FAIL redir_mem_addr got=%h exp=4", mem_addr); end
        tick();
        checks++; if (if_pc !== 32'h10) begin fails++; $display("FAIL redir_land_pc got=%h exp=10", if_pc); end
        checks++; if (if_valid !== 1'b1) begin fails++; $display("FAIL redir_land_valid got=%b exp=1", if_valid); end
        checks++; if (if_instr !== mem[4]) begin fails++; $display("FAIL redir_land_instr got=%h exp=%h", if_instr, mem[4]); end
    endtask

    task automatic test_misaligned();
        redirect = 1'b1; redirect_pc = 32'h13;
        tick();
        redirect = 1'b0;
        checks++; if (mem_addr !== 32'd4) begin fails++; $display("FAIL misal_mem_addr got=%h exp=4", mem_addr); end
        tick();
        checks++; if (if_pc !== 32'h10) begin fails++; $display("FAIL misal_if_pc got=%h exp=10", if_pc); end
    endtask

    task automatic test_fault();
        redirect = 1'b1; redirect_pc = 32'h70;
        tick();
        redirect = 1'b0;
        tick();
        tick();
        checks++; if (if_instr !== mem[29]) begin fails++; $display("FAIL fault_last_word got=%h exp=%h", if_instr, mem[29]); end
        checks++; if (mem_addr !== 32'd30) begin fails++; $display("FAIL fault_mem_addr got=%h exp=1e", mem_addr); end
        checks++; if (fetch_fault !== 1'b0) begin fails++; $display("FAIL fault_early got=%b exp=0", fetch_fault); end
        tick();
        checks++; if (if_valid !== 1'b0) begin fails++; $display("FAIL fault_valid got=%b exp=0", if_valid); end
        checks++; if (if_instr !== NOP) begin fails++; $display("FAIL fault_instr got=%h exp=%h", if_instr, NOP); end
        checks++; if (fetch_fault !== 1'b1) begin fails++; $display("FAIL fault_set got=%b exp=1", fetch_fault); end
        checks++; if (mem_addr !== 32'd31) begin fails++; $display("FAIL fault_pc_adv got=%h exp=1f", mem_addr); end
        redirect = 1'b1; redirect_pc = 32'h0;
        tick();
        redirect = 1'b0;
        tick();
        checks++; if (if_instr !== mem[0] || if_valid !== 1'b1) begin fails++; $display("FAIL fault_recover got=%h/%b exp=%h/1", if_instr, if_valid, mem[0]); end
        checks++; if (fetch_fault !== 1'b1) begin fails++; $display("FAIL fault_sticky got=%b exp=1", fetch_fault); end
        // PC wrap at top of address space
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        tick();
        redirect = 1'b0;
        checks++; if (mem_addr !== 32'h3FFF_FFFF) begin fails++; $display("FAIL wrap_top got=%h exp=3fffffff", mem_addr); end
        tick();
        checks++; if (mem_addr !== 32'h0) begin fails++; $display("FAIL wrap_zero got=%h exp=0", mem_addr); end
        tick();
        checks++; if (if_instr !== mem[0] || if_pc !== 32'h0) begin fails++; $display("FAIL wrap_fetch got=%h@%h exp=%h@0", if_instr, if_pc, mem[0]); end
    endtask

    task automatic test_reset_perf();
        logic [31:0] exp_fetch;
        logic [31:0] exp_stall;
        stall = 1'b1;
        tick();
        rst = 1'b1; redirect = 1'b1; redirect_pc = 32'h40;
        tick();
        rst = 1'b0; redirect = 1'b0; stall = 1'b0;
        checks++; if (if_valid !== 1'b0 || if_instr !== NOP || if_pc !== 32'h0) begin fails++; $display("FAIL rst_mid_if got=%b/%h/%h exp=0/%h/0", if_valid, if_instr, if_pc, NOP); end
        checks++; if (mem_addr !== 32'h0) begin fails++; $display("FAIL rst_mid_addr got=%h exp=0", mem_addr); end
        checks++; if (fetch_fault !== 1'b0) begin fails++; $display("FAIL rst_mid_fault got=%b exp=0", fetch_fault); end
        checks++; if (fetch_count !== 32'h0 || stall_count !== 32'h0) begin fails++; $display("FAIL rst_mid_counts got=%0d/%0d exp=0/0", fetch_count, stall_count); end
        for (int i = 0; i < 10; i++) tick();
        stall = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        stall = 1'b0;
`ifdef IFETCH_PERF_EN
        exp_fetch = 32'd10; exp_stall = 32'd3;
`else
        exp_fetch = 32'd0;  exp_stall = 32'd0;
`endif
        checks++; if (fetch_count !== exp_fetch) begin fails++; $display("FAIL perf_fetch got=%0d exp=%0d", fetch_count, exp_fetch); end
        checks++; if (stall_count !== exp_stall) begin fails++; $display("FAIL perf_stall got=%0d exp=%0d", stall_count, exp_stall); end
        checks++; if (if_instr !== mem[9] || if_pc !== 32'h24) begin fails++; $display("FAIL perf_hold got=%h@%h exp=%h@24", if_instr, if_pc, mem[9]); end
    endtask

    initial begin
        checks = 0;
        fails  = 0;
        rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
        for (int i = 0; i < 32; i++) mem[i] = {16'hA5C0, 16'(i)} ^ 32'h0000_3300;
        test_reset();
        test_advance();
        test_stall();
        test_redirect();
        test_misaligned();
        test_fault();
        test_reset_perf();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
